// File: rtl/memory_responder_if.sv
// CPU-side memory bus: data port (read/write) and instruction fetch port (read-only).
// The master modport belongs to the cpu; the slave modport belongs to the responder.
interface memory_responder_if;
    logic        data_write_enable;
    logic [15:0] data_address;
    logic [15:0] data_write_data;
    logic [15:0] data_read_data;
    logic [15:0] instruction_address;
    logic [15:0] instruction_read_data;

    modport master (
        output data_write_enable, data_address, data_write_data, instruction_address,
        input  data_read_data, instruction_read_data
    );

    modport slave (
        input  data_write_enable, data_address, data_write_data, instruction_address,
        output data_read_data, instruction_read_data
    );
endinterface

// File: rtl/memory_responder.sv
// Memory-side responder: dual-port word RAM plus a four-register I/O page
// (LEDs, synchronized switches, prescaled timer, sticky button events).
module memory_responder #(
    parameter int          ADDRESS_WIDTH = 10,
    parameter logic [15:0] IO_BASE       = 16'hFF00,
    parameter int          PRESCALE      = 50000,
    parameter              INIT_FILE     = "program.hex"
) (
    input  logic                clock,
    input  logic                reset,
    memory_responder_if.slave   bus,
    input  logic [9:0]          switches,
    input  logic [3:0]          buttons,
    output logic [9:0]          leds
);

    localparam int RAM_DEPTH = 1 << ADDRESS_WIDTH;
    localparam int PW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESCALE_LAST = PW'(PRESCALE - 1);

    localparam logic [1:0] OFF_LED    = 2'd0;
    localparam logic [1:0] OFF_SWITCH = 2'd1;
    localparam logic [1:0] OFF_TIMER  = 2'd2;
    localparam logic [1:0] OFF_EVENT  = 2'd3;

    // The RAM image named by INIT_FILE is placed by the device configuration flow.
    logic [15:0] ram [0:RAM_DEPTH-1];

    logic [15:0] data_q;
    logic [15:0] instr_q;
    logic [15:0] timer;
    logic [PW-1:0] prescale;
    logic [9:0]  switch_meta;
    logic [9:0]  switch_sync;
    logic [3:0]  button_meta;
    logic [3:0]  button_sync;
    logic [3:0]  button_prev;
    logic [3:0]  flags;

    function automatic logic in_ram(input logic [15:0] a);
        return 32'(a) < 32'(RAM_DEPTH);
    endfunction

    function automatic logic in_io(input logic [15:0] a);
        return (17'(a) >= 17'(IO_BASE)) && (17'(a) <= 17'(IO_BASE) + 17'd3);
    endfunction

    logic                     d_ram;
    logic                     d_io;
    logic                     i_ram;
    logic [1:0]               d_off;
    logic [ADDRESS_WIDTH-1:0] d_idx;
    logic [ADDRESS_WIDTH-1:0] i_idx;
    logic                     tick;
    logic [3:0]               rise;
    logic [3:0]               clear;
    logic                     wr_led;
    logic                     wr_timer;
    logic                     wr_event;
    logic [15:0]              d_read;
    logic [15:0]              i_read;

    assign d_ram = in_ram(bus.data_address);
    assign d_io  = in_io(bus.data_address);
    assign i_ram = in_ram(bus.instruction_address);
    assign d_off = bus.data_address[1:0] - IO_BASE[1:0];
    assign d_idx = bus.data_address[ADDRESS_WIDTH-1:0];
    assign i_idx = bus.instruction_address[ADDRESS_WIDTH-1:0];

    // RAM takes priority if the I/O page is ever placed inside the RAM range.
    assign wr_led   = bus.data_write_enable && !d_ram && d_io && (d_off == OFF_LED);
    assign wr_timer = bus.data_write_enable && !d_ram && d_io && (d_off == OFF_TIMER);
    assign wr_event = bus.data_write_enable && !d_ram && d_io && (d_off == OFF_EVENT);

    assign tick  = (prescale == PRESCALE_LAST);
    assign rise  = button_sync & ~button_prev;
    assign clear = wr_event ? bus.data_write_data[3:0] : 4'h0;

    always_comb begin
        d_read = 16'h0000;
        if (d_ram) begin
            d_read = ram[d_idx];
        end else if (d_io) begin
            case (d_off)
                OFF_LED:    d_read = {6'b0, leds};
                OFF_SWITCH: d_read = {6'b0, switch_sync};
                OFF_TIMER:  d_read = timer;
                OFF_EVENT:  d_read = {12'b0, flags};
                default:    d_read = 16'h0000;
            endcase
        end
    end

    always_comb begin
        i_read = 16'h0000;
        if (i_ram) begin
            i_read = ram[i_idx];
        end
    end

    // Write gated by reset so a held reset never disturbs RAM contents.
    always_ff @(posedge clock) begin
        if (reset && bus.data_write_enable && d_ram) begin
            ram[d_idx] <= bus.data_write_data;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            data_q      <= 16'h0000;
            instr_q     <= 16'h0000;
            leds        <= 10'h000;
            timer       <= 16'h0000;
            prescale    <= '0;
            switch_meta <= 10'h000;
            switch_sync <= 10'h000;
            button_meta <= 4'h0;
            button_sync <= 4'h0;
            button_prev <= 4'h0;
            flags       <= 4'h0;
        end else begin
            data_q      <= d_read;
            instr_q     <= i_read;
            switch_meta <= switches;
            switch_sync <= switch_meta;
            button_meta <= buttons;
            button_sync <= button_meta;
            button_prev <= button_sync;
            flags       <= (flags & ~clear) | rise;

            if (wr_led) begin
                leds <= bus.data_write_data[9:0];
            end

            if (wr_timer) begin
                timer    <= bus.data_write_data;
                prescale <= '0;
            end else if (tick) begin
                timer    <= timer + 16'd1;
                prescale <= '0;
            end else begin
                prescale <= prescale + PW'(1);
            end
        end
    end

    assign bus.data_read_data        = data_q;
    assign bus.instruction_read_data = instr_q;

endmodule

// File: tb/tb_memory_responder.sv
// Directed bench for memory_responder: vector table for RAM/LED/decode behaviour,
// hand sequences for synchronizers, timer, button events and asynchronous reset.
module tb_memory_responder;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [9:0] switches = 10'h000;
    logic [3:0] buttons = 4'h0;
    logic [9:0] leds;

    int tests = 0;
    int failures = 0;

    memory_responder_if bus();

    memory_responder #(
        .ADDRESS_WIDTH(10),
        .IO_BASE(16'hFF00),
        .PRESCALE(4),
        .INIT_FILE("")
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus),
        .switches(switches),
        .buttons(buttons),
        .leds(leds)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] iaddr;
        logic [15:0] exp_d;
        logic [15:0] exp_i;
        logic [9:0]  exp_leds;
    } vec_t;

    vec_t vecs[15];

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                         input logic [15:0] iaddr);
        bus.data_write_enable   = we;
        bus.data_address        = addr;
        bus.data_write_data     = wdata;
        bus.instruction_address = iaddr;
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0]  = '{1'b1, 16'h0005, 16'hBEEF, 16'h0005, 16'h0000, 16'h0000, 10'h000};
        vecs[1]  = '{1'b0, 16'h0005, 16'h0000, 16'h0005, 16'hBEEF, 16'hBEEF, 10'h000};
        vecs[2]  = '{1'b1, 16'h0010, 16'h1234, 16'h0010, 16'h0000, 16'h0000, 10'h000};
        vecs[3]  = '{1'b0, 16'h0010, 16'h0000, 16'h0010, 16'h1234, 16'h1234, 10'h000};
        vecs[4]  = '{1'b1, 16'hFF00, 16'h03FF, 16'hFF00, 16'h0000, 16'h0000, 10'h3FF};
        vecs[5]  = '{1'b0, 16'hFF00, 16'h0000, 16'hFF00, 16'h03FF, 16'h0000, 10'h3FF};
        vecs[6]  = '{1'b0, 16'h8000, 16'h0000, 16'h8000, 16'h0000, 16'h0000, 10'h3FF};
        vecs[7]  = '{1'b1, 16'h8000, 16'hABCD, 16'h0005, 16'h0000, 16'hBEEF, 10'h3FF};
        vecs[8]  = '{1'b0, 16'h8000, 16'h0000, 16'h8000, 16'h0000, 16'h0000, 10'h3FF};
        vecs[9]  = '{1'b1, 16'hFF01, 16'hFFFF, 16'h03FF, 16'h0000, 16'h7777, 10'h3FF};
        vecs[10] = '{1'b0, 16'hFF01, 16'h0000, 16'h0400, 16'h0000, 16'h0000, 10'h3FF};
        vecs[11] = '{1'b1, 16'h03FF, 16'h5A5A, 16'h03FF, 16'h7777, 16'h7777, 10'h3FF};
        vecs[12] = '{1'b0, 16'h03FF, 16'h0000, 16'h0000, 16'h5A5A, 16'h1111, 10'h3FF};
        vecs[13] = '{1'b1, 16'hFF00, 16'hFC15, 16'h0000, 16'h03FF, 16'h1111, 10'h015};
        vecs[14] = '{1'b0, 16'hFF00, 16'h0000, 16'h0010, 16'h0015, 16'h1234, 10'h015};

        drive(1'b0, 16'h0000, 16'h0000, 16'h0000);

        // Reset state, held across edges
        repeat (2) @(posedge clock);
        #1;
        check("reset_data_read", bus.data_read_data, 16'h0000);
        check("reset_instr_read", bus.instruction_read_data, 16'h0000);
        check("reset_leds", {6'b0, leds}, 16'h0000);
        reset = 1'b1;

        // Known RAM contents for the vector table
        drive(1'b1, 16'h0000, 16'h1111, 16'h0000); step();
        drive(1'b1, 16'h0005, 16'h0000, 16'h0000); step();
        drive(1'b1, 16'h0010, 16'h0000, 16'h0000); step();
        drive(1'b1, 16'h03FF, 16'h7777, 16'h0000); step();

        for (int v = 0; v < 15; v++) begin
            drive(vecs[v].we, vecs[v].addr, vecs[v].wdata, vecs[v].iaddr);
            step();
            check($sformatf("vec%0d_data", v), bus.data_read_data, vecs[v].exp_d);
            check($sformatf("vec%0d_instr", v), bus.instruction_read_data, vecs[v].exp_i);
            check($sformatf("vec%0d_leds", v), {6'b0, leds}, {6'b0, vecs[v].exp_leds});
        end

        // Switch synchronizer: visible only from the third edge after the change
        drive(1'b0, 16'hFF01, 16'h0000, 16'h0000);
        switches = 10'h2A5;
        step();
        step();
        check("switch_edge2", bus.data_read_data, 16'h0000);
        step();
        check("switch_edge3", bus.data_read_data, 16'h02A5);

        // Button event: set, hold (not clear-on-read), write-1-to-clear
        drive(1'b0, 16'hFF03, 16'h0000, 16'h0000);
        step();
        check("event_idle", bus.data_read_data, 16'h0000);
        buttons = 4'b0100;
        repeat (3) step();
        buttons = 4'b0000;
        repeat (3) step();
        check("event_set", bus.data_read_data, 16'h0004);
        step();
        check("event_sticky", bus.data_read_data, 16'h0004);
        drive(1'b1, 16'hFF03, 16'h0004, 16'h0000);
        step();
        drive(1'b0, 16'hFF03, 16'h0000, 16'h0000);
        step();
        check("event_cleared", bus.data_read_data, 16'h0000);
        repeat (3) step();

        // Clear lands on the same edge as a new rising edge: set wins
        buttons = 4'b0100;
        step();
        step();
        drive(1'b1, 16'hFF03, 16'h0004, 16'h0000);
        step();
        drive(1'b0, 16'hFF03, 16'h0000, 16'h0000);
        step();
        step();
        check("event_set_beats_clear", bus.data_read_data, 16'h0004);
        buttons = 4'b0000;

        // Asynchronous reset mid-run
        drive(1'b0, 16'h0005, 16'h0000, 16'h0005);
        step();
        check("pre_reset_data", bus.data_read_data, 16'hBEEF);
        #2;
        reset = 1'b0;
        #1;
        check("async_reset_data", bus.data_read_data, 16'h0000);
        check("async_reset_instr", bus.instruction_read_data, 16'h0000);
        check("async_reset_leds", {6'b0, leds}, 16'h0000);
        drive(1'b1, 16'hFF00, 16'h03FF, 16'h0005);
        step();
        check("reset_write_ignored", {6'b0, leds}, 16'h0000);
        check("reset_hold_data", bus.data_read_data, 16'h0000);

        // Timer with PRESCALE=4, counted from reset release
        drive(1'b0, 16'hFF02, 16'h0000, 16'h0000);
        reset = 1'b1;
        repeat (4) step();
        check("timer_before_tick", bus.data_read_data, 16'h0000);
        step();
        check("timer_first_tick", bus.data_read_data, 16'h0001);
        drive(1'b1, 16'hFF02, 16'hFFFF, 16'h0000);
        step();
        drive(1'b0, 16'hFF02, 16'h0000, 16'h0000);
        repeat (4) step();
        check("timer_loaded", bus.data_read_data, 16'hFFFF);
        step();
        check("timer_wrap", bus.data_read_data, 16'h0000);
        repeat (2) step();
        drive(1'b1, 16'hFF02, 16'h1000, 16'h0000);
        step();
        drive(1'b0, 16'hFF02, 16'h0000, 16'h0000);
        step();
        check("timer_write_beats_tick", bus.data_read_data, 16'h1000);
        repeat (3) step();
        check("timer_prescale_cleared", bus.data_read_data, 16'h1000);
        step();
        check("timer_next_tick", bus.data_read_data, 16'h1001);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule

// File: doc/memory_responder.md
Name: memory_responder

Overview: Memory-side responder for the CPU's two memory interfaces: the instruction fetch port (read-only) and the data port (read/write). Holds a dual-port word RAM and a small memory-mapped I/O page with LEDs, switches, a button event latch and a free-running timer. Sits beside the cpu at the top level and drives both read-data buses.

Parameters:
ADDRESS_WIDTH, 10, log2 of RAM depth in 16-bit words; RAM covers addresses 0 .. 2^ADDRESS_WIDTH-1.
IO_BASE, 16'hFF00, first address of the I/O page; the page is IO_BASE .. IO_BASE+3.
PRESCALE, 50000, clocks per timer tick; must be at least 1.
INIT_FILE, "program.hex", hex image loaded into RAM at configuration.

Ports:
clock  input  1  system clock; all state updates on the rising edge
reset  input  1  asynchronous, active-low reset
data_write_enable  input  1  data port write strobe
data_address  input  16  data port word address
data_write_data  input  16  data port write data
data_read_data  output  16  data port read data, registered
instruction_address  input  16  fetch word address
instruction_read_data  output  16  fetch data, registered
switches  input  10  asynchronous board switches
buttons  input  4  asynchronous board buttons, active-high
leds  output  10  LED register

Behaviour:
- Address decode, identical for both ports:
  - RAM when address < 2^ADDRESS_WIDTH.
  - IO when IO_BASE <= address <= IO_BASE+3.
  - Otherwise unmapped.
- Read latency is 1 cycle on both ports. The value sampled at edge N appears on read_data after edge N and holds until the next edge. Both ports read every cycle; there is no read enable.
- RAM reads:
  - Read-before-write: a data write and a read of the same address at the same edge return the old word on both ports.
  - The write lands at that edge.
- Unmapped addresses: reads return 16'h0000 and writes are ignored.
- Instruction port reading the IO page returns 16'h0000 and has no side effects.
- IO page (offset from IO_BASE):
  - +0 LED: read/write. Write loads data_write_data[9:0] into leds. Reads return {6'b0, leds}.
  - +1 SWITCH: read-only. switches passes through a 2-flop synchronizer. A read returns {6'b0, sync_switches}. Writes are ignored.
  - +2 TIMER: read/write 16-bit counter.
    - A prescaler counts 0..PRESCALE-1. On its wrap, TIMER increments, and 16'hFFFF wraps to 0.
    - A write loads TIMER from data_write_data and clears the prescaler. If a write and a tick occur at the same edge, the write wins.
  - +3 EVENT: 4-bit sticky flags, read as {12'b0, flags}.
    - A button passes through a 2-flop synchronizer. A rising edge of the synchronized signal (a third flop holds the previous value) sets its flag.
    - Write-1-to-clear using data_write_data[3:0].
    - If a set and a clear of the same bit occur at the same edge, the set wins.
- Reset (reset low, asynchronous):
  - Clears to 0: data_read_data, instruction_read_data, leds, TIMER, the prescaler, EVENT flags and all synchronizer flops.
  - RAM contents are not cleared.
  - While reset is low, writes are ignored and both read-data outputs stay 0.
  - After release, the first edge samples addresses normally.
- Reset asserted mid-write: no guarantee for the RAM word at that edge. The IO registers reset regardless.
- Data port reads of the IO page have no side effects. EVENT is not clear-on-read.

Test Plan:
- Write 16'hBEEF to address 16'h0005, then read 16'h0005 on both ports the next cycle -> both read_data equal 16'hBEEF one cycle after the address is sampled.
- Same edge: data write 16'h1234 to 16'h0010 while the instruction port reads 16'h0010 (old value 16'h0000) -> instruction_read_data is 16'h0000; a read of 16'h0010 the next cycle returns 16'h1234.
- Write 16'h03FF to 16'hFF00 -> leds becomes 10'h3FF after the edge; a read of 16'hFF00 returns 16'h03FF. A read of unmapped address 16'h8000 returns 16'h0000. The instruction port at 16'hFF00 returns 16'h0000.
- Set switches to 10'h2A5 -> a read of 16'hFF01 shows 16'h02A5 no earlier than the third edge after the change.
- With PRESCALE=4: after reset, TIMER reads 16'h0001 after 4 clocks. Write 16'hFFFF, then 4 clocks later it reads 16'h0000. A write coinciding with a tick loads the written value.
- Pulse buttons[2] high -> EVENT reads 16'h0004. Write 16'h0004 to 16'hFF03 at the same edge as a new rising edge on buttons[2] -> the flag stays set. Assert reset mid-run -> every output is 0 immediately, without waiting for a clock.
